mul_iter: RTL and testbench

- Iterative radix-2 shift-add multiplier for the EX stage.
- Consumes register-file operands for MULT/MULTU and produces a 2W-bit product for the HI/LO registers.
- Uses one W-bit add-with-carry step per cycle.
- Stalls the pipeline via busy until done.

---
 rtl/mul_iter_pkg.sv | 19 +
 rtl/mul_iter_if.sv | 26 ++
 rtl/mul_add_step.sv | 14 +
 rtl/mul_iter.sv | 117 +++++++++++
 tb/tb_mul_iter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative multiplier: sequencer states and the
// issue-to-result latency the stall logic budgets for.
package mul_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  localparam int MUL_W   = 32;
  localparam int MUL_LAT = MUL_W + 1;

  function automatic int mul_lat(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/mul_iter_if.sv
// Operand/result bundle between the EX stage and the iterative multiplier.
interface mul_iter_if #(
  parameter int W = 32
);
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         prod_zero;
  logic         prod_sign;

  modport master (
    output start, is_signed, a, b, flush,
    input  busy, done, hi, lo, prod_zero, prod_sign
  );

  modport slave (
    input  start, is_signed, a, b, flush,
    output busy, done, hi, lo, prod_zero, prod_sign
  );
endinterface

// File: rtl/mul_add_step.sv
// One shift-add iteration: conditionally add the multiplicand to the upper
// accumulator half, keeping the carry so the shift never loses a bit.
module mul_add_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] acc_hi,
  input  logic [W-1:0] ma,
  input  logic         add,
  output logic [W:0]   sum_c
);

  assign sum_c = add ? ({1'b0, acc_hi} + {1'b0, ma}) : {1'b0, acc_hi};

endmodule

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: magnitudes are multiplied unsigned over W
// steps, then the sign is applied once in the FIX cycle.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_iter_if.slave  bus
);

  mul_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     ma_q, ma_d;
  logic             neg_q, neg_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             prod_zero_q, prod_zero_d;
  logic             prod_sign_q, prod_sign_d;

  logic [W:0]       step;
  logic [2*W-1:0]   res;
  logic [W-1:0]     abs_a;
  logic [W-1:0]     abs_b;

  mul_add_step #(.W(W)) u_step (
    .acc_hi (acc_q[2*W-1:W]),
    .ma     (ma_q),
    .add    (acc_q[0]),
    .sum_c  (step)
  );

  // The most negative value maps onto itself, which is the correct magnitude unsigned.
  assign abs_a = (bus.is_signed && bus.a[W-1]) ? -bus.a : bus.a;
  assign abs_b = (bus.is_signed && bus.b[W-1]) ? -bus.b : bus.b;
  assign res   = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ma_d        = ma_q;
    neg_d       = neg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    prod_zero_d = prod_zero_q;
    prod_sign_d = prod_sign_q;

    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            ma_d    = abs_a;
            acc_d   = {{W{1'b0}}, abs_b};
            neg_d   = bus.is_signed & (bus.a[W-1] ^ bus.b[W-1]);
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_d = {step, acc_q[W-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          hi_d        = res[2*W-1:W];
          lo_d        = res[W-1:0];
          prod_zero_d = (res == '0);
          prod_sign_d = res[2*W-1];
          state_d     = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ma_q        <= '0;
      neg_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      prod_zero_q <= 1'b0;
      prod_sign_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ma_q        <= ma_d;
      neg_q       <= neg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      prod_zero_q <= prod_zero_d;
      prod_sign_q <= prod_sign_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.prod_zero = prod_zero_q;
  assign bus.prod_sign = prod_sign_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed table, multi-cycle corner
// sequences, and randomized operands against a plain-arithmetic product model.
module tb_mul_iter;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] prev_res = '0;

  mul_iter_if #(.W(W)) bus ();

  mul_iter #(.W(W), .CW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        sign;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives operands for one edge (E0), then scrambles them to show they are not re-sampled.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    bus.is_signed = sgn;
    bus.a         = a;
    bus.b         = b;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
    chk("busy_after_start", bus.busy, 1);
    chk("no_done_after_start", bus.done, 0);
  endtask

  task automatic wait_done(input int mid, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (n == mid) begin
        bus.start     = 1'b1;
        bus.is_signed = 1'b1;
        bus.a         = $urandom;
        bus.b         = $urandom;
      end
      tick();
      bus.start = 1'b0;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] exp, input int n);
    chk({tag, "_latency"}, 64'(n), 64'(LAT));
    chk({tag, "_hi"}, bus.hi, exp[63:32]);
    chk({tag, "_lo"}, bus.lo, exp[31:0]);
    chk({tag, "_zero"}, bus.prod_zero, (exp == 64'd0));
    chk({tag, "_sign"}, bus.prod_sign, exp[63]);
    prev_res = exp;
  endtask

  initial begin
    int n;
    int seen;
    bit sgn;
    logic [31:0] ra, rb;

    vecs[0] = '{0, 32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A, 1'b0, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1};
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1};
    vecs[3] = '{1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{0, 32'd9,        32'd9,        32'h0000_0000, 32'h0000_0051, 1'b0, 1'b0};

    rst_n = 1'b0; bus.start = 1'b0; bus.flush = 1'b0;
    bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_zero", bus.prod_zero, 0);
    chk("rst_sign", bus.prod_sign, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", bus.busy, 0);

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(-1, n);
      chk($sformatf("vec%0d_latency", i), 64'(n), 64'(LAT));
      chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
      chk($sformatf("vec%0d_zero", i), bus.prod_zero, vecs[i].zero);
      chk($sformatf("vec%0d_sign", i), bus.prod_sign, vecs[i].sign);
      chk($sformatf("vec%0d_busy_in_done", i), bus.busy, 0);
      prev_res = {vecs[i].hi, vecs[i].lo};
      tick();
      chk($sformatf("vec%0d_done_one_cycle", i), bus.done, 0);
      chk($sformatf("vec%0d_hold_lo", i), bus.lo, vecs[i].lo);
    end

    // Mid-RUN start is ignored; then back-to-back issue from the DONE cycle.
    issue(0, 32'd7, 32'd6);
    wait_done(10, n);
    check_result("b2b_first", model(0, 32'd7, 32'd6), n);
    issue(0, 32'd9, 32'd9);
    wait_done(-1, n);
    check_result("b2b_second", 64'h51, n);
    tick();

    // Flush at E0+10: abort without disturbing the previous result.
    issue(1, 32'hFFFF_FFF9, 32'd3);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_done", bus.done, 0);
    chk("flush_hi_hold", bus.hi, prev_res[63:32]);
    chk("flush_lo_hold", bus.lo, prev_res[31:0]);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    chk("flush_no_done", 64'(seen), 0);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_over_start_busy", bus.busy, 0);
    issue(1, 32'hFFFF_FFF9, 32'd3);
    wait_done(-1, n);
    check_result("after_flush", model(1, 32'hFFFF_FFF9, 32'd3), n);
    tick();

    // Reset at E0+5, with start held high during reset.
    issue(0, 32'd100, 32'd200);
    repeat (4) tick();
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd4;
    tick();
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    chk("midrst_zero", bus.prod_zero, 0);
    chk("midrst_sign", bus.prod_sign, 0);
    tick();
    chk("rst_start_ignored", bus.busy, 0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    tick();
    chk("post_rst_busy", bus.busy, 0);
    prev_res = '0;

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'h0000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      issue(sgn, ra, rb);
      wait_done(-1, n);
      check_result($sformatf("rand%0d", i), model(sgn, ra, rb), n);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
